// File: rtl/simon_pkg.sv
// Shared state encoding, colour codes and LFSR step for the Simon sequencer.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_GAP = 3'd3,
        INPUT    = 3'd4,
        FAIL     = 3'd5,
        WIN      = 3'd6
    } state_t;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;
    localparam logic [1:0] COL_Y = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois right-shift step; the bit shifted out selects whether the taps are applied.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Galois LFSR that supplies the next colour; steps only when asked.
module simon_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] state
);
    import simon_pkg::*;

    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon round controller: grows a random colour sequence, plays it out, then
// checks the player's presses against it in order.
module simon_seq_ctrl #(
    parameter int          MAX_LEN     = 16,
    parameter int          SHOW_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_color,
    output logic                         show_valid,
    output logic [1:0]                   show_color,
    output logic                         await_input,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         game_over,
    output logic                         win
);
    import simon_pkg::*;

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t        state;
    logic [LW-1:0] length;
    logic [LW-1:0] idx;
    logic [LW-1:0] idx_inc;
    logic [TW-1:0] timer;
    logic [1:0]    mem [MAX_LEN];
    logic [1:0]    lfsr_lo;
    logic [13:0]   lfsr_hi_unused;
    logic          last_idx;
    logic          timer_done;
    logic [1:0]    first_color;

    simon_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .advance(state == ADD),
        .state  ({lfsr_hi_unused, lfsr_lo})
    );

    assign idx_inc    = idx + LW'(1);
    assign last_idx   = (idx == length - LW'(1));
    assign timer_done = (timer == TW'(SHOW_CYCLES - 1));
    assign level      = length;
    // On the very first round mem[0] is being written in the same ADD cycle, so bypass it.
    assign first_color = (length == '0) ? lfsr_lo : mem[0];

    // NOTE: the sequence memory has no reset; every entry is written in ADD before it is ever read.
    always_ff @(posedge clock) begin
        if (state == ADD) begin
            mem[length[AW-1:0]] <= lfsr_lo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            length      <= '0;
            idx         <= '0;
            timer       <= '0;
            show_valid  <= 1'b0;
            show_color  <= COL_R;
            await_input <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
        end else begin
            case (state)
                IDLE, FAIL, WIN: begin
                    if (start) begin
                        length    <= '0;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    length     <= length + LW'(1);
                    idx        <= '0;
                    timer      <= '0;
                    show_valid <= 1'b1;
                    show_color <= first_color;
                    state      <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (timer_done) begin
                        timer      <= '0;
                        show_valid <= 1'b0;
                        show_color <= COL_R;
                        state      <= SHOW_GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SHOW_GAP: begin
                    if (timer_done) begin
                        timer <= '0;
                        if (last_idx) begin
                            idx         <= '0;
                            await_input <= 1'b1;
                            state       <= INPUT;
                        end else begin
                            idx        <= idx_inc;
                            show_valid <= 1'b1;
                            show_color <= mem[idx_inc[AW-1:0]];
                            state      <= SHOW_ON;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                INPUT: begin
                    if (btn_valid) begin
                        if (btn_color != mem[idx[AW-1:0]]) begin
                            await_input <= 1'b0;
                            game_over   <= 1'b1;
                            state       <= FAIL;
                        end else if (last_idx) begin
                            await_input <= 1'b0;
                            if (length == LW'(MAX_LEN)) begin
                                win   <= 1'b1;
                                state <= WIN;
                            end else begin
                                state <= ADD;
                            end
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Scoreboard bench for simon_seq_ctrl: directed rounds on a 16-deep game plus
// a 2-deep instance for the win path and mid-show reset.
module tb_simon_seq_ctrl;
    import simon_pkg::*;

    localparam int SHOW = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, btn_valid;
    logic [1:0] btn_color;
    logic       show_valid, await_input, game_over, win;
    logic [1:0] show_color;
    logic [4:0] level;

    logic       start_b, btn_valid_b;
    logic [1:0] btn_color_b;
    logic       show_valid_b, await_input_b, game_over_b, win_b;
    logic [1:0] show_color_b;
    logic [1:0] level_b;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_q[$];

    simon_seq_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .btn_valid  (btn_valid),
        .btn_color  (btn_color),
        .show_valid (show_valid),
        .show_color (show_color),
        .await_input(await_input),
        .level      (level),
        .game_over  (game_over),
        .win        (win)
    );

    simon_seq_ctrl #(.MAX_LEN(2)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .start      (start_b),
        .btn_valid  (btn_valid_b),
        .btn_color  (btn_color_b),
        .show_valid (show_valid_b),
        .show_color (show_color_b),
        .await_input(await_input_b),
        .level      (level_b),
        .game_over  (game_over_b),
        .win        (win_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        tick();
        btn_valid = 1'b0;
    endtask

    task automatic press_b(input logic [1:0] c);
        btn_valid_b = 1'b1;
        btn_color_b = c;
        tick();
        btn_valid_b = 1'b0;
    endtask

    task automatic wait_await(input int budget);
        int n = 0;
        while (!await_input && n < budget) begin
            tick();
            n++;
        end
        check("await_reached", await_input, 1);
    endtask

    task automatic wait_await_b(input int budget);
        int n = 0;
        while (!await_input_b && n < budget) begin
            tick();
            n++;
        end
        check("b_await_reached", await_input_b, 1);
    endtask

    // Display monitor: pops one expected colour per lit period and times lit/dark spans.
    initial begin : monitor
        logic       prev_sv = 1'b0;
        logic       prev_aw = 1'b0;
        logic       in_gap = 1'b0;
        logic       col_bad = 1'b0;
        logic       gap_dirty = 1'b0;
        logic [1:0] cur_col = 2'd0;
        int         on_len = 0;
        int         gap_len = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_sv = 1'b0;
                prev_aw = 1'b0;
                in_gap  = 1'b0;
            end else begin
                if (show_valid && !prev_sv) begin
                    if (in_gap) begin
                        check("gap_len", gap_len, SHOW);
                        check("gap_dark", gap_dirty, 0);
                    end
                    check("sb_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("sb_color", show_color, exp_q.pop_front());
                    cur_col = show_color;
                    on_len  = 1;
                    col_bad = 1'b0;
                    in_gap  = 1'b0;
                end else if (show_valid) begin
                    on_len++;
                    if (show_color != cur_col) col_bad = 1'b1;
                end else if (prev_sv) begin
                    check("on_len", on_len, SHOW);
                    check("on_stable", col_bad, 0);
                    in_gap    = 1'b1;
                    gap_len   = 1;
                    gap_dirty = (show_color != 2'd0);
                end else if (in_gap && !await_input) begin
                    gap_len++;
                    if (show_color != 2'd0) gap_dirty = 1'b1;
                end
                if (await_input && !prev_aw) begin
                    check("await_after_gap", in_gap, 1);
                    check("await_gap_len", gap_len, SHOW);
                    in_gap = 1'b0;
                end
                prev_sv = show_valid;
                prev_aw = await_input;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_color = 2'd0;
        start_b = 1'b0; btn_valid_b = 1'b0; btn_color_b = 2'd0;
        tick();
        tick();
        check("rst_show_valid", show_valid, 0);
        check("rst_show_color", show_color, 0);
        check("rst_await", await_input, 0);
        check("rst_level", level, 0);
        check("rst_game_over", game_over, 0);
        check("rst_win", win, 0);
        check("rst_b_show_valid", show_valid_b, 0);
        check("rst_b_level", level_b, 0);
        check("rst_b_win", win_b, 0);
        reset = 1'b0;

        press(COL_G);
        check("idle_btn_level", level, 0);
        check("idle_btn_await", await_input, 0);
        tick();

        // Game 1: seed 0xACE1 gives G first.
        exp_q.push_back(COL_G);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("add_show_valid", show_valid, 0);
        check("add_level", level, 0);
        tick();
        check("first_show_valid", show_valid, 1);
        check("first_show_color", show_color, COL_G);
        check("first_level", level, 1);
        repeat (7) tick();
        check("await_t9", await_input, 0);
        tick();
        check("await_t10", await_input, 1);

        // Round 1: LFSR 0xE270 adds R; stray presses during the display are ignored.
        exp_q.push_back(COL_G);
        exp_q.push_back(COL_R);
        press(COL_G);
        check("r1_add_await", await_input, 0);
        check("r1_add_level", level, 1);
        for (int i = 0; i < 12; i++) begin
            btn_valid = i[0];
            btn_color = COL_Y;
            tick();
        end
        btn_valid = 1'b0;
        wait_await(40);
        check("r1_level", level, 2);

        // Round 2: start during the display is ignored.
        exp_q.push_back(COL_G);
        exp_q.push_back(COL_R);
        exp_q.push_back(COL_R);
        press(COL_G);
        check("r2_mid_await", await_input, 1);
        check("r2_mid_level", level, 2);
        press(COL_R);
        for (int i = 0; i < 12; i++) begin
            start = (i == 5);
            tick();
        end
        start = 1'b0;
        check("r2_start_ignored", level, 3);
        wait_await(60);
        check("r2_level", level, 3);

        // Round 3: LFSR 0x389C adds another R.
        exp_q.push_back(COL_G);
        exp_q.push_back(COL_R);
        exp_q.push_back(COL_R);
        exp_q.push_back(COL_R);
        press(COL_G);
        press(COL_R);
        press(COL_R);
        wait_await(80);
        check("r3_level", level, 4);

        // Wrong third press ends the game; later presses change nothing.
        press(COL_G);
        press(COL_R);
        press(COL_Y);
        check("fail_game_over", game_over, 1);
        check("fail_await", await_input, 0);
        check("fail_level", level, 4);
        press(COL_R);
        press(COL_G);
        check("fail_sticky", game_over, 1);
        check("fail_level_hold", level, 4);
        check("fail_await_hold", await_input, 0);

        // Restart without reseed: LFSR 0x1C4E gives B.
        exp_q.push_back(COL_B);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_clear", game_over, 0);
        check("restart_level0", level, 0);
        tick();
        check("restart_level1", level, 1);
        check("restart_color", show_color, COL_B);
        wait_await(20);
        check("sb_drained", exp_q.size(), 0);

        // Two-deep instance: G, then G R wins.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_await_b(30);
        press_b(COL_G);
        wait_await_b(40);
        check("b_level2", level_b, 2);
        press_b(COL_G);
        check("b_mid_win", win_b, 0);
        press_b(COL_R);
        check("b_win", win_b, 1);
        check("b_win_level", level_b, 2);
        check("b_win_await", await_input_b, 0);
        check("b_win_game_over", game_over_b, 0);
        press_b(COL_G);
        check("b_win_sticky", win_b, 1);

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_restart_win", win_b, 0);
        tick();
        tick();
        check("b_mid_show", show_valid_b, 1);
        reset = 1'b1;
        tick();
        check("b_rst_show_valid", show_valid_b, 0);
        check("b_rst_show_color", show_color_b, 0);
        check("b_rst_await", await_input_b, 0);
        check("b_rst_level", level_b, 0);
        check("b_rst_game_over", game_over_b, 0);
        check("b_rst_win", win_b, 0);
        reset = 1'b0;
        tick();
        tick();
        check("b_idle_show_valid", show_valid_b, 0);
        check("b_idle_level", level_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simon_seq_ctrl.md
Name: simon_seq_ctrl

Overview:
Upstream sequencer for the Simon game datapath; it sits ahead of the single-press colour checker.
- Generates a pseudo-random colour sequence and grows it by one colour per round.
- Plays the sequence out on a display interface, then checks the player's button presses against it in order.
- Reports the current level, game-over and win status.

Parameters:
MAX_LEN, 16, maximum sequence length (rounds to win); 2..64.
SHOW_CYCLES, 4, clock cycles each colour is lit, and also each dark gap after it; >=1.
LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be non-zero.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle pulse; begins a new game (accepted in IDLE, FAIL, WIN).
btn_valid  in  1  player press strobe, one cycle per press.
btn_color  in  2  pressed colour, valid with btn_valid: 0=R, 1=G, 2=B, 3=Y.
show_valid  out  1  high while a sequence colour is being displayed.
show_color  out  2  colour being displayed; 0 when show_valid=0.
await_input  out  1  high while in INPUT state.
level  out  $clog2(MAX_LEN+1)  current sequence length.
game_over  out  1  sticky; high in FAIL.
win  out  1  sticky; high in WIN.

Behaviour:
- Reset (sync, clock edge with reset=1):
  - state=IDLE; all outputs 0; length=0; idx=0; timer=0.
  - LFSR<=LFSR_SEED. Sequence memory contents are don't-care.
- Reset has priority over every other input, including mid-SHOW and mid-INPUT.
- States are IDLE, ADD, SHOW_ON, SHOW_GAP, INPUT, FAIL, WIN.
- IDLE / FAIL / WIN:
  - Hold state and outputs until start=1.
  - On start: length<=0, clear game_over/win, go to ADD.
- ADD (1 cycle):
  - mem[length]<=LFSR[1:0]; length<=length+1.
  - Advance LFSR once; idx<=0; timer<=0; go to SHOW_ON.
- LFSR:
  - 16-bit Galois, right shift, taps 16'hB400.
  - next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances only in ADD.
  - Not reseeded on start, so successive games differ.
- SHOW_ON:
  - show_valid=1, show_color=mem[idx] for exactly SHOW_CYCLES cycles, then go to SHOW_GAP with timer reset.
- SHOW_GAP:
  - show_valid=0 for SHOW_CYCLES cycles.
  - Then if idx==length-1: idx<=0 and go to INPUT; else idx<=idx+1 and go to SHOW_ON.
- INPUT (await_input=1); on btn_valid:
  - btn_color != mem[idx]: go to FAIL (game_over<=1).
  - Match and idx==length-1: if length==MAX_LEN go to WIN (win<=1); else go to ADD.
  - Match otherwise: idx<=idx+1.
- Input filtering:
  - btn_valid outside INPUT is ignored; no effect, no error.
  - start outside IDLE/FAIL/WIN is ignored.
- Timing:
  - start at edge t: ADD during cycle t+1; show_valid first high in cycle t+2.
  - Correct final press at edge p: next ADD in cycle p+1.
- level equals length at all times; it holds its final value in FAIL/WIN until the next start.
- Outputs are registered (Moore): show_*, await_input, game_over and win are decoded from registered state.
- Width rules: idx and length are $clog2(MAX_LEN+1) bits; memory is MAX_LEN x 2 bits.

Decomposition:
- Package simon_pkg holds:
  - state localparams (IDLE..WIN);
  - colour codes R=0, G=1, B=2, Y=3;
  - LFSR_TAPS=16'hB400.
- Sub-module simon_lfsr has ports clock, reset, advance, seed parameter and 16-bit state output.
- FSM, timer, index and memory stay in simon_seq_ctrl.

Test Plan:
- Reset then start, SHOW_CYCLES=4 -> level=1; show_valid high cycles t+2..t+5 with show_color=1 (G, from seed 0xACE1); then 4 dark cycles; await_input=1.
- Round 1, press G -> ADD; level=2; display shows G then R (LFSR 0xE270 gives colour 0); each 4 on / 4 off.
- Rounds 2-3 correct presses G,R then G,R,R -> level=4; 4th colour R (LFSR 0x7138 then 0x389C).
- At level 2, press G then Y (expected R) -> game_over=1, await_input=0; later presses ignored; start clears game_over and level=1.
- btn_valid pulses during SHOW_ON/SHOW_GAP -> no state change, display timing unchanged.
- MAX_LEN=2: complete both rounds correctly -> win=1, level=2; reset asserted mid-SHOW -> next cycle all outputs 0, state IDLE.
